multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of alu_op; the low ALU_OP_W bits of the opcode field supply it.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum number of MEM-state cycles to wait for mem_ack before the controller faults.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port run, input, 1: fetch enable, sampled in FETCH.
REQ-006 Port instr, input, 6: opcode field from instruction memory, valid when imem_ack=1.
REQ-007 Ports imem_req (output, 1) and imem_ack (input, 1): instruction fetch handshake.
REQ-008 Ports mem_req (output, 1), mem_we (output, 1) and mem_ack (input, 1): data memory handshake.
REQ-009 Ports c_in and z_in, input, 1 each: ALU/shifter carry and zero flags.
REQ-010 Port ir_we, output, 1: instruction register load strobe.
REQ-011 Port pc_we, output, 1: PC load strobe.
REQ-012 Port pc_src, output, 2: PC source select; 00=PC+1, 01=PC+offset, 10=constant.
REQ-013 Port alu_op, output, ALU_OP_W: ALU operation code.
REQ-014 Port alu_src_const, output, 1: ALU B operand select; 1=immediate, 0=register.
REQ-015 Port rf_we, output, 1: register file write enable.
REQ-016 Port rf_src, output, 2: register file write source; 00=ALU, 01=memory, 10=shifter.
REQ-017 Port rf_rd2_rd, output, 1: read-port-2 address select; 1=rd.
REQ-018 Port busy, output, 1: high in every state except IDLE-FETCH with run=0.
REQ-019 Port error, output, 1: sticky fault flag.

Function
REQ-020 Opcode decode SHALL be: [5:4]=00 R-type, 01 I-type, [5:3]=100 shift, 101 memory, 110 conditional branch, [5:2]=1110 jump, 1111 illegal.
REQ-021 Memory function instr[2:1]: 00 LDM, 01 STM, 1x illegal; branch function instr[2:1]: 00 BZ, 01 BNZ, 10 BC, 11 BNC.
REQ-022 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, ERROR; all control outputs are 0 unless this section states otherwise.
REQ-023 FETCH: imem_req=run; when imem_ack=1 and run=1, ir_we=1 for one cycle, the opcode is latched, and the next state is DECODE; otherwise the FSM holds.
REQ-024 DECODE, jump: pc_we=1, pc_src=10, next state FETCH (2 cycles per jump, ack cycle included).
REQ-025 DECODE, branch: pc_we=1; pc_src=01 if taken on the registered flags (z_q/c_q), else 00; next state FETCH.
REQ-026 DECODE, R/I/shift: next state EXEC; DECODE, memory: next state MEM, timeout counter cleared.
REQ-027 DECODE, illegal opcode or memory function: next state ERROR.
REQ-028 EXEC: rf_we=1, pc_we=1, pc_src=00, and c_q/z_q load c_in/z_in; next state FETCH.
REQ-029 EXEC, R-type: alu_src_const=0 and rf_src=00; I-type: alu_src_const=1; shift: rf_src=10.
REQ-030 alu_op SHALL equal latched opcode[ALU_OP_W-1:0] in every state; it is 0 after reset.
REQ-031 MEM: mem_req=1, alu_src_const=1, mem_we=1 for STM, rf_rd2_rd=1 for STM; the counter increments each cycle without mem_ack.
REQ-032 MEM with mem_ack=1: pc_we=1, pc_src=00, rf_we=1 and rf_src=01 for LDM only; next state FETCH.
REQ-033 MEM with no ack when the counter equals MEM_TIMEOUT-1: next state ERROR; mem_req SHALL be 0 from the following cycle.
REQ-034 mem_ack SHALL be ignored outside MEM, and imem_ack outside FETCH.
REQ-035 ERROR: error=1 and all strobes 0; the FSM holds until reset.
REQ-036 Flags SHALL change only in EXEC; branches and memory operations leave them unchanged.

Reset
REQ-037 When rst_n=0: state=FETCH, opcode=0, c_q=z_q=0, counter=0, error=0, and all outputs 0 immediately, without waiting for a clock.
REQ-038 Reset asserted mid-MEM or mid-FETCH SHALL drop mem_req/imem_req asynchronously; any in-flight access is abandoned.

Verification
REQ-039 Fetch R-type 000011 with c_in=1, z_in=0 -> ir_we pulse, then DECODE, then EXEC with rf_we=1, alu_op=011, pc_we=1; c_q=1 afterwards.
REQ-040 Load LDM (101000) with mem_ack on the 3rd MEM cycle -> mem_req high for 3 cycles, then rf_src=01, rf_we=1 and pc_we=1 in the ack cycle.
REQ-041 Set z_q=1, then issue BZ (110000) -> pc_src=01; issue BNZ (110010) -> pc_src=00; both with pc_we=1.
REQ-042 STM with no mem_ack -> mem_we=1 for 15 cycles, then ERROR with error=1 held until rst_n=0.
REQ-043 Illegal opcode 111100 or memory function 101100 -> ERROR after DECODE, with no rf_we or pc_we pulse.
REQ-044 rst_n low while in MEM -> all outputs 0 asynchronously; after release the FSM is in FETCH with imem_req=run.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Controller-side handshake and control bundle for the multicycle datapath.
// master = controller, slave = datapath/memories (or a testbench driving them).
interface multicycle_controller_if #(parameter int ALU_OP_W = 3);
  logic                run;
  logic [5:0]          instr;
  logic                imem_req, imem_ack;
  logic                mem_req, mem_we, mem_ack;
  logic                c_in, z_in;
  logic                ir_we, pc_we;
  logic [1:0]          pc_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src_const, rf_we;
  logic [1:0]          rf_src;
  logic                rf_rd2_rd, busy, error;

  modport master (
    input  run, instr, imem_ack, mem_ack, c_in, z_in,
    output imem_req, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op,
           alu_src_const, rf_we, rf_src, rf_rd2_rd, busy, error
  );
  modport slave (
    output run, instr, imem_ack, mem_ack, c_in, z_in,
    input  imem_req, mem_req, mem_we, ir_we, pc_we, pc_src, alu_op,
           alu_src_const, rf_we, rf_src, rf_rd2_rd, busy, error
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/ERROR with a bounded
// data-memory wait and sticky fault state.
module multicycle_controller #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_ERROR} state_t;

  state_t             state_q, state_d;
  logic [5:0]         opcode_q, opcode_d;
  logic               c_q, c_d, z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic imem_req_c, ir_we_c, pc_we_c, alu_src_const_c, rf_we_c, rf_rd2_rd_c;
  logic mem_req_c, mem_we_c, busy_c, error_c;
  logic [1:0] pc_src_c, rf_src_c;

  // Class decode of the latched opcode
  logic is_r, is_i, is_sh, is_mem, is_br, is_jmp, mem_ld, mem_st, br_taken;
  assign is_r   = (opcode_q[5:4] == 2'b00);
  assign is_i   = (opcode_q[5:4] == 2'b01);
  assign is_sh  = (opcode_q[5:3] == 3'b100);
  assign is_mem = (opcode_q[5:3] == 3'b101);
  assign is_br  = (opcode_q[5:3] == 3'b110);
  assign is_jmp = (opcode_q[5:2] == 4'b1110);
  assign mem_ld = (opcode_q[2:1] == 2'b00);
  assign mem_st = (opcode_q[2:1] == 2'b01);

  always_comb begin
    case (opcode_q[2:1])
      2'b00:   br_taken = z_q;
      2'b01:   br_taken = ~z_q;
      2'b10:   br_taken = c_q;
      default: br_taken = ~c_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      c_q      <= c_d;
      z_q      <= z_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;  opcode_d = opcode_q;
    c_d = c_q;  z_d = z_q;  cnt_d = cnt_q;
    imem_req_c = 1'b0;  ir_we_c = 1'b0;  pc_we_c = 1'b0;  pc_src_c = 2'b00;
    alu_src_const_c = 1'b0;  rf_we_c = 1'b0;  rf_src_c = 2'b00;
    rf_rd2_rd_c = 1'b0;  mem_req_c = 1'b0;  mem_we_c = 1'b0;
    busy_c = 1'b1;  error_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = bus.run;
        busy_c     = bus.run;
        if (bus.run && bus.imem_ack) begin
          ir_we_c  = 1'b1;
          opcode_d = bus.instr;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_jmp) begin
          pc_we_c = 1'b1;  pc_src_c = 2'b10;  state_d = S_FETCH;
        end else if (is_br) begin
          pc_we_c = 1'b1;  pc_src_c = br_taken ? 2'b01 : 2'b00;  state_d = S_FETCH;
        end else if (is_r || is_i || is_sh) begin
          state_d = S_EXEC;
        end else if (is_mem && !opcode_q[2]) begin
          state_d = S_MEM;  cnt_d = '0;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        rf_we_c = 1'b1;  pc_we_c = 1'b1;
        alu_src_const_c = is_i;
        rf_src_c = is_sh ? 2'b10 : 2'b00;
        c_d = bus.c_in;  z_d = bus.z_in;
        state_d = S_FETCH;
      end
      S_MEM: begin
        mem_req_c = 1'b1;  alu_src_const_c = 1'b1;
        mem_we_c = mem_st;  rf_rd2_rd_c = mem_st;
        if (bus.mem_ack) begin
          pc_we_c = 1'b1;  rf_we_c = mem_ld;
          rf_src_c = mem_ld ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERROR: error_c = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

  // Reset gates every output combinationally so requests drop without a clock
  assign bus.imem_req      = imem_req_c & rst_n;
  assign bus.ir_we         = ir_we_c & rst_n;
  assign bus.pc_we         = pc_we_c & rst_n;
  assign bus.pc_src        = pc_src_c & {2{rst_n}};
  assign bus.alu_op        = opcode_q[ALU_OP_W-1:0] & {ALU_OP_W{rst_n}};
  assign bus.alu_src_const = alu_src_const_c & rst_n;
  assign bus.rf_we         = rf_we_c & rst_n;
  assign bus.rf_src        = rf_src_c & {2{rst_n}};
  assign bus.rf_rd2_rd     = rf_rd2_rd_c & rst_n;
  assign bus.mem_req       = mem_req_c & rst_n;
  assign bus.mem_we        = mem_we_c & rst_n;
  assign bus.busy          = busy_c & rst_n;
  assign bus.error         = error_c & rst_n;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle traces predicted from
// opcode class rules, directed table plus randomized instruction stream.
module tb_multicycle_controller;
  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.ALU_OP_W(3)) bus ();
  multicycle_controller #(.ALU_OP_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_const, rf_we;
    logic [1:0] rf_src;
    logic       rf_rd2_rd, mem_req, mem_we, busy, error;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       ci, zi;
    int         ackcyc;
    int         exp_cyc;
    bit         exp_err;
  } vec_t;

  int checks = 0, failures = 0;
  logic [5:0] m_op = '0;
  logic m_c = 1'b0, m_z = 1'b0;

  function automatic outs_t sample();
    outs_t s;
    s.imem_req = bus.imem_req;  s.ir_we = bus.ir_we;  s.pc_we = bus.pc_we;
    s.pc_src = bus.pc_src;  s.alu_op = bus.alu_op;
    s.alu_src_const = bus.alu_src_const;  s.rf_we = bus.rf_we;
    s.rf_src = bus.rf_src;  s.rf_rd2_rd = bus.rf_rd2_rd;
    s.mem_req = bus.mem_req;  s.mem_we = bus.mem_we;
    s.busy = bus.busy;  s.error = bus.error;
    return s;
  endfunction

  function automatic outs_t base();
    outs_t e = '0;
    e.busy = 1'b1;
    e.alu_op = m_op[2:0];
    return e;
  endfunction

  // 0 R, 1 I, 2 shift, 3 mem, 4 branch, 5 jump, 6 illegal
  function automatic int op_class(input logic [5:0] op);
    int v = int'(op);
    if (v < 16) return 0;
    if (v < 32) return 1;
    if (v < 40) return 2;
    if (v < 48) return 3;
    if (v < 56) return 4;
    if (v < 60) return 5;
    return 6;
  endfunction

  task automatic check_o(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic noise();
    bus.imem_ack = 1'($urandom);  bus.instr = 6'($urandom);
    bus.mem_ack = 1'($urandom);   bus.c_in = 1'($urandom);
    bus.z_in = 1'($urandom);
  endtask

  task automatic cyc(input outs_t e, input string name);
    @(negedge clk);
    check_o(name, sample(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    outs_t e;
    bus.run = 1'b1;
    rst_n = 1'b0;
    #1;
    check_o("rst_async", sample(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_op = '0;  m_c = 1'b0;  m_z = 1'b0;
    bus.imem_ack = 1'b0;
    e = base();  e.imem_req = 1'b1;
    cyc(e, "post_rst_fetch");
  endtask

  task automatic exec_instr(input logic [5:0] op, input logic ci, input logic zi,
                            input int ackcyc, output int ncyc, output bit err);
    outs_t e;
    int cls;
    bit stm, acked, taken;
    ncyc = 0;  err = 0;
    cls = op_class(op);
    stm = (op[2:1] == 2'b01);
    noise();
    bus.run = 1'b1;  bus.imem_ack = 1'b1;  bus.instr = op;
    e = base();  e.imem_req = 1'b1;  e.ir_we = 1'b1;
    cyc(e, "fetch");  ncyc++;
    m_op = op;
    noise();
    e = base();
    if (cls == 5) begin
      e.pc_we = 1'b1;  e.pc_src = 2'b10;
    end else if (cls == 4) begin
      case (op[2:1])
        2'd0: taken = m_z;
        2'd1: taken = !m_z;
        2'd2: taken = m_c;
        default: taken = !m_c;
      endcase
      e.pc_we = 1'b1;  e.pc_src = taken ? 2'b01 : 2'b00;
    end
    cyc(e, "decode");  ncyc++;
    if (cls <= 2) begin
      noise();
      bus.c_in = ci;  bus.z_in = zi;
      e = base();  e.rf_we = 1'b1;  e.pc_we = 1'b1;
      e.alu_src_const = (cls == 1);
      e.rf_src = (cls == 2) ? 2'b10 : 2'b00;
      cyc(e, "exec");  ncyc++;
      m_c = ci;  m_z = zi;
    end else if (cls == 3 && op[2] == 1'b0) begin
      acked = 0;
      for (int k = 0; k < MEM_TIMEOUT && !acked; k++) begin
        noise();
        bus.mem_ack = (k + 1 == ackcyc);
        e = base();  e.mem_req = 1'b1;  e.alu_src_const = 1'b1;
        e.mem_we = stm;  e.rf_rd2_rd = stm;
        if (k + 1 == ackcyc) begin
          acked = 1;
          e.pc_we = 1'b1;  e.rf_we = !stm;  e.rf_src = stm ? 2'b00 : 2'b01;
        end
        cyc(e, "mem");  ncyc++;
      end
      err = !acked;
    end else if (cls != 4 && cls != 5) begin
      err = 1;
    end
    if (err) begin
      for (int k = 0; k < 2; k++) begin
        noise();
        e = base();  e.error = 1'b1;
        cyc(e, "error_hold");
      end
      do_reset();
    end
  endtask

  vec_t tbl[$];
  outs_t e;
  int nc;
  bit er;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b1;  bus.instr = '0;  bus.imem_ack = 1'b1;
    bus.mem_ack = 1'b1;  bus.c_in = 1'b0;  bus.z_in = 1'b0;
    #3;
    check_o("reset_state", sample(), '0);
    @(posedge clk);  @(posedge clk);  #1;
    rst_n = 1'b1;

    bus.run = 1'b0;  bus.imem_ack = 1'b1;  bus.instr = 6'h2a;
    e = base();  e.busy = 1'b0;
    cyc(e, "idle_run0");
    cyc(e, "idle_run0_hold");
    bus.run = 1'b1;  bus.imem_ack = 1'b0;
    e = base();  e.imem_req = 1'b1;
    cyc(e, "fetch_stall");

    // {op, c_in, z_in, ack cycle, expected cycles, expected fault}
    tbl.push_back('{6'b000011, 1'b1, 1'b0, 0, 3, 1'b0});
    tbl.push_back('{6'b101000, 1'b0, 1'b0, 3, 5, 1'b0});
    tbl.push_back('{6'b000001, 1'b0, 1'b1, 0, 3, 1'b0});
    tbl.push_back('{6'b110000, 1'b0, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{6'b110010, 1'b0, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{6'b110100, 1'b0, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{6'b010101, 1'b1, 1'b0, 0, 3, 1'b0});
    tbl.push_back('{6'b110110, 1'b0, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{6'b110100, 1'b0, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{6'b100111, 1'b0, 1'b0, 0, 3, 1'b0});
    tbl.push_back('{6'b111001, 1'b0, 1'b0, 0, 2, 1'b0});
    tbl.push_back('{6'b101010, 1'b0, 1'b0, 1, 3, 1'b0});
    tbl.push_back('{6'b101010, 1'b0, 1'b0, 0, 17, 1'b1});
    tbl.push_back('{6'b111100, 1'b0, 1'b0, 0, 2, 1'b1});
    tbl.push_back('{6'b101100, 1'b0, 1'b0, 0, 2, 1'b1});
    foreach (tbl[i]) begin
      exec_instr(tbl[i].op, tbl[i].ci, tbl[i].zi, tbl[i].ackcyc, nc, er);
      check_i($sformatf("vec%0d_cycles", i), nc, tbl[i].exp_cyc);
      check_i($sformatf("vec%0d_fault", i), int'(er), int'(tbl[i].exp_err));
    end

    // Reset in the middle of a data-memory wait
    noise();
    bus.run = 1'b1;  bus.imem_ack = 1'b1;  bus.instr = 6'b101010;
    e = base();  e.imem_req = 1'b1;  e.ir_we = 1'b1;
    cyc(e, "rmem_fetch");
    m_op = 6'b101010;
    noise();
    cyc(base(), "rmem_decode");
    for (int k = 0; k < 2; k++) begin
      noise();  bus.mem_ack = 1'b0;
      e = base();  e.mem_req = 1'b1;  e.alu_src_const = 1'b1;
      e.mem_we = 1'b1;  e.rf_rd2_rd = 1'b1;
      cyc(e, "rmem_wait");
    end
    bus.mem_ack = 1'b0;
    #1;
    check_o("rmem_pre_rst", sample(), e);
    do_reset();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.run = 1'b0;  noise();
        e = base();  e.busy = 1'b0;
        cyc(e, "rand_idle");
      end
      exec_instr(6'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4)), nc, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
